// File: rtl/carfield_pkg.sv
// carfield_pkg: shared types and constants for the Carfield address map.
//   rule_t        - one address window (base, size, enable), sized for the
//                   widest supported address so one type serves every width.
//   rule_table_t  - reset-contents array for up to MaxRules windows.
//   idx_width()   - width of a rule index; never zero, even for one rule.
//   Carfield*     - platform address-map constants.
package carfield_pkg;

  localparam int unsigned MaxRules     = 64;
  localparam int unsigned MaxAddrWidth = 64;

  typedef struct packed {
    logic [MaxAddrWidth-1:0] base;
    logic [MaxAddrWidth-1:0] size;
    logic                    en;
  } rule_t;

  typedef rule_t [MaxRules-1:0] rule_table_t;

  // Platform address-map windows.
  localparam logic [47:0] CarfieldL2Base     = 48'h0000_7800_0000;
  localparam logic [47:0] CarfieldL2Size     = 48'h0000_0020_0000;
  localparam logic [47:0] CarfieldPeriphBase = 48'h0000_2000_0000;
  localparam logic [47:0] CarfieldPeriphSize = 48'h0000_0000_2000;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/carfield_addr_rule_match.sv
// carfield_addr_rule_match: single-window range comparator.
//   en_i, base_i, size_i - window description
//   addr_i               - address under test
//   match_o              - en && size != 0 && base <= addr < base + size
// The upper bound is formed one bit wider than the address so a window
// that ends exactly at (or straddles) the top of the address space does
// not wrap around to zero.
module carfield_addr_rule_match #(
  parameter int unsigned AddrWidth = 48
) (
  input  logic                 en_i,
  input  logic [AddrWidth-1:0] base_i,
  input  logic [AddrWidth-1:0] size_i,
  input  logic [AddrWidth-1:0] addr_i,
  output logic                 match_o
);

  logic [AddrWidth:0] addr_x;
  logic [AddrWidth:0] base_x;
  logic [AddrWidth:0] limit_x;

  assign addr_x  = {1'b0, addr_i};
  assign base_x  = {1'b0, base_i};
  assign limit_x = base_x + {1'b0, size_i};

  assign match_o = en_i && (size_i != '0) && (addr_x >= base_x) && (addr_x < limit_x);

endmodule

// File: rtl/carfield_addr_map_unit.sv
// carfield_addr_map_unit: programmable address decoder with lockable table.
//   clk_i, rst_i                     - clock, synchronous active-high reset
//   cfg_we_i/idx/base/size/en        - rule write port
//   cfg_lock_i                       - freeze table until reset
//   cfg_err_o                        - one-cycle pulse after a rejected write
//   locked_o                         - table frozen
//   req_valid_i/req_ready_o/addr     - lookup request
//   rsp_valid_o/rsp_ready_i          - registered lookup result
//   rsp_hit_o/rsp_multi_o/rsp_idx_o  - lowest matching rule, overlap flag
//   miss_cnt_o                       - saturating count of no-hit results
// Handshake: a transfer happens on a rising edge where valid && ready.
// The response register holds its contents while rsp_valid_o && !rsp_ready_i,
// and a new request is accepted whenever the response slot is empty or is
// being drained in the same cycle, giving one lookup per cycle.
module carfield_addr_map_unit
  import carfield_pkg::*;
#(
  parameter int unsigned NumRules     = 16,
  parameter int unsigned AddrWidth    = 48,
  parameter rule_table_t DefaultRules = '0,
  parameter int unsigned CntWidth     = 16
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               cfg_we_i,
  input  logic [idx_width(NumRules)-1:0]     cfg_idx_i,
  input  logic [AddrWidth-1:0]               cfg_base_i,
  input  logic [AddrWidth-1:0]               cfg_size_i,
  input  logic                               cfg_en_i,
  input  logic                               cfg_lock_i,
  output logic                               cfg_err_o,
  output logic                               locked_o,
  input  logic                               req_valid_i,
  output logic                               req_ready_o,
  input  logic [AddrWidth-1:0]               req_addr_i,
  output logic                               rsp_valid_o,
  input  logic                               rsp_ready_i,
  output logic                               rsp_hit_o,
  output logic                               rsp_multi_o,
  output logic [idx_width(NumRules)-1:0]     rsp_idx_o,
  output logic [CntWidth-1:0]                miss_cnt_o
);

  localparam int unsigned IdxW = idx_width(NumRules);

  logic [AddrWidth-1:0] base_q [NumRules];
  logic [AddrWidth-1:0] size_q [NumRules];
  logic [NumRules-1:0]  en_q;
  logic                 locked_q, cfg_err_q;
  logic                 rsp_valid_q, rsp_hit_q, rsp_multi_q;
  logic [IdxW-1:0]      rsp_idx_q;
  logic [CntWidth-1:0]  miss_cnt_q;

  logic [NumRules-1:0]  match;
  logic                 hit_d, multi_d;
  logic [IdxW-1:0]      idx_d;
  logic                 wr_accept, req_accept;

  for (genvar g = 0; g < NumRules; g++) begin : g_rule
    carfield_addr_rule_match #(.AddrWidth(AddrWidth)) u_match (
      .en_i   (en_q[g]),
      .base_i (base_q[g]),
      .size_i (size_q[g]),
      .addr_i (req_addr_i),
      .match_o(match[g])
    );
  end

  // Lowest-index match wins; any later match marks an overlap.
  always_comb begin
    hit_d   = 1'b0;
    multi_d = 1'b0;
    idx_d   = '0;
    for (int i = 0; i < NumRules; i++) begin
      if (match[i]) begin
        if (hit_d) begin
          multi_d = 1'b1;
        end else begin
          hit_d = 1'b1;
          idx_d = IdxW'(i);
        end
      end
    end
  end

  // locked_q is the pre-lock value, so a write issued alongside the lock
  // pulse still lands.
  assign wr_accept   = cfg_we_i && !locked_q && (32'(cfg_idx_i) < NumRules);
  assign req_ready_o = !rsp_valid_q || rsp_ready_i;
  assign req_accept  = req_valid_i && req_ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumRules; i++) begin
        base_q[i] <= DefaultRules[i].base[AddrWidth-1:0];
        size_q[i] <= DefaultRules[i].size[AddrWidth-1:0];
        en_q[i]   <= DefaultRules[i].en;
      end
      locked_q    <= 1'b0;
      cfg_err_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_multi_q <= 1'b0;
      rsp_idx_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      for (int i = 0; i < NumRules; i++) begin
        if (wr_accept && (32'(cfg_idx_i) == i)) begin
          base_q[i] <= cfg_base_i;
          size_q[i] <= cfg_size_i;
          en_q[i]   <= cfg_en_i;
        end
      end
      locked_q  <= locked_q || cfg_lock_i;
      cfg_err_q <= cfg_we_i && !wr_accept;
      if (req_accept) begin
        rsp_valid_q <= 1'b1;
        rsp_hit_q   <= hit_d;
        rsp_multi_q <= multi_d;
        rsp_idx_q   <= idx_d;
        if (!hit_d && (miss_cnt_q != {CntWidth{1'b1}})) begin
          miss_cnt_q <= miss_cnt_q + CntWidth'(1);
        end
      end else if (rsp_ready_i) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign cfg_err_o   = cfg_err_q;
  assign locked_o    = locked_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_hit_o   = rsp_hit_q;
  assign rsp_multi_o = rsp_multi_q;
  assign rsp_idx_o   = rsp_idx_q;
  assign miss_cnt_o  = miss_cnt_q;

endmodule

// File: tb/tb_carfield_addr_map_unit.sv
// Directed bench for carfield_addr_map_unit (12 rules, 48-bit addresses,
// 4-bit miss counter so saturation is reachable).
module tb_carfield_addr_map_unit;

  localparam int unsigned NR = 12;
  localparam int unsigned AW = 48;
  localparam int unsigned CW = 4;
  localparam int unsigned IW = 4;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          cfg_we_i = 1'b0;
  logic [IW-1:0] cfg_idx_i = '0;
  logic [AW-1:0] cfg_base_i = '0;
  logic [AW-1:0] cfg_size_i = '0;
  logic          cfg_en_i = 1'b0;
  logic          cfg_lock_i = 1'b0;
  logic          cfg_err_o, locked_o;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic [AW-1:0] req_addr_i = '0;
  logic          rsp_valid_o;
  logic          rsp_ready_i = 1'b1;
  logic          rsp_hit_o, rsp_multi_o;
  logic [IW-1:0] rsp_idx_o;
  logic [CW-1:0] miss_cnt_o;

  int tests_run = 0;
  int fails = 0;
  int exp_miss = 0;

  carfield_addr_map_unit #(
    .NumRules(NR), .AddrWidth(AW), .CntWidth(CW)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cfg_we_i(cfg_we_i), .cfg_idx_i(cfg_idx_i), .cfg_base_i(cfg_base_i),
    .cfg_size_i(cfg_size_i), .cfg_en_i(cfg_en_i), .cfg_lock_i(cfg_lock_i),
    .cfg_err_o(cfg_err_o), .locked_o(locked_o),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_hit_o(rsp_hit_o), .rsp_multi_o(rsp_multi_o), .rsp_idx_o(rsp_idx_o),
    .miss_cnt_o(miss_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_rule(input int idx, input logic [AW-1:0] base,
                            input logic [AW-1:0] size, input logic en,
                            input logic exp_err, input string tag);
    cfg_we_i = 1'b1; cfg_idx_i = IW'(idx);
    cfg_base_i = base; cfg_size_i = size; cfg_en_i = en;
    step();
    cfg_we_i = 1'b0;
    chk({tag, "_err"}, 64'(cfg_err_o), 64'(exp_err));
  endtask

  task automatic note_result(input logic exp_hit);
    if (!exp_hit && exp_miss < 15) exp_miss++;
  endtask

  task automatic lookup(input logic [AW-1:0] addr, input logic exp_hit,
                        input int exp_idx, input logic exp_multi, input string tag);
    req_valid_i = 1'b1; req_addr_i = addr; rsp_ready_i = 1'b1;
    step();
    req_valid_i = 1'b0;
    note_result(exp_hit);
    chk({tag, "_valid"}, 64'(rsp_valid_o), 64'd1);
    chk({tag, "_hit"},   64'(rsp_hit_o),   64'(exp_hit));
    chk({tag, "_idx"},   64'(rsp_idx_o),   64'(exp_idx));
    chk({tag, "_multi"}, 64'(rsp_multi_o), 64'(exp_multi));
    chk({tag, "_miss"},  64'(miss_cnt_o),  64'(exp_miss));
  endtask

  initial begin
    // Reset
    rst_i = 1'b1;
    step(); step();
    rst_i = 1'b0;
    chk("rst_locked", 64'(locked_o), 64'd0);
    chk("rst_valid",  64'(rsp_valid_o), 64'd0);
    chk("rst_hit",    64'(rsp_hit_o), 64'd0);
    chk("rst_multi",  64'(rsp_multi_o), 64'd0);
    chk("rst_idx",    64'(rsp_idx_o), 64'd0);
    chk("rst_err",    64'(cfg_err_o), 64'd0);
    chk("rst_miss",   64'(miss_cnt_o), 64'd0);
    chk("rst_ready",  64'(req_ready_o), 64'd1);

    // Basic window, upper boundary
    write_rule(0, 48'h7800_0000, 48'h20_0000, 1'b1, 1'b0, "wr0");
    lookup(48'h781F_FFFF, 1'b1, 0, 1'b0, "l2_last");
    lookup(48'h7820_0000, 1'b0, 0, 1'b0, "l2_past");
    lookup(48'h7800_0000, 1'b1, 0, 1'b0, "l2_first");

    // Overlap: lowest index wins
    write_rule(2, 48'h2000_0000, 48'h2000, 1'b1, 1'b0, "wr2");
    write_rule(5, 48'h2000_1000, 48'h1000, 1'b1, 1'b0, "wr5");
    lookup(48'h2000_1000, 1'b1, 2, 1'b1, "ovl");
    lookup(48'h2000_0FFF, 1'b1, 2, 1'b0, "ovl_lo");
    lookup(48'h2000_1FFF, 1'b1, 2, 1'b1, "ovl_hi");
    lookup(48'h2000_2000, 1'b0, 0, 1'b0, "ovl_past");

    // Window crossing the top of the address space
    write_rule(7, 48'hFFFF_FFFF_F000, 48'h2000, 1'b1, 1'b0, "wr7");
    lookup(48'hFFFF_FFFF_FFFF, 1'b1, 7, 1'b0, "top");
    lookup(48'h0, 1'b0, 0, 1'b0, "wrap0");

    // Disabled rule and zero-size rule never match
    write_rule(8, 48'h1000, 48'h1000, 1'b0, 1'b0, "wr8");
    lookup(48'h1800, 1'b0, 0, 1'b0, "disabled");
    write_rule(9, 48'h3000, 48'h0, 1'b1, 1'b0, "wr9");
    lookup(48'h3000, 1'b0, 0, 1'b0, "size0");

    // Write and lookup in the same cycle: lookup sees old table
    cfg_we_i = 1'b1; cfg_idx_i = 4'd1; cfg_base_i = 48'h5000;
    cfg_size_i = 48'h100; cfg_en_i = 1'b1;
    req_valid_i = 1'b1; req_addr_i = 48'h5000;
    step();
    cfg_we_i = 1'b0; req_valid_i = 1'b0;
    note_result(1'b0);
    chk("wrlk_hit", 64'(rsp_hit_o), 64'd0);
    chk("wrlk_miss", 64'(miss_cnt_o), 64'(exp_miss));
    lookup(48'h5000, 1'b1, 1, 1'b0, "wrlk_after");

    // Out-of-range index
    write_rule(NR, 48'h6000, 48'h100, 1'b1, 1'b1, "wr_oor");
    step();
    chk("oor_err_clear", 64'(cfg_err_o), 64'd0);

    // Back-pressure: hold a response, then drain one per cycle
    rsp_ready_i = 1'b0; req_valid_i = 1'b1; req_addr_i = 48'h7800_0000;
    step();
    req_addr_i = 48'h2000_1000;
    chk("bp_valid", 64'(rsp_valid_o), 64'd1);
    for (int c = 0; c < 5; c++) begin
      chk("bp_ready", 64'(req_ready_o), 64'd0);
      chk("bp_hold_idx", 64'(rsp_idx_o), 64'd0);
      chk("bp_hold_multi", 64'(rsp_multi_o), 64'd0);
      chk("bp_hold_hit", 64'(rsp_hit_o), 64'd1);
      step();
    end
    rsp_ready_i = 1'b1;
    #1;
    chk("bp_release_ready", 64'(req_ready_o), 64'd1);
    step();
    req_addr_i = 48'h5000;
    chk("bp_r1_idx", 64'(rsp_idx_o), 64'd2);
    chk("bp_r1_multi", 64'(rsp_multi_o), 64'd1);
    step();
    req_valid_i = 1'b0;
    chk("bp_r2_idx", 64'(rsp_idx_o), 64'd1);
    chk("bp_r2_multi", 64'(rsp_multi_o), 64'd0);
    chk("bp_r2_valid", 64'(rsp_valid_o), 64'd1);
    step();
    chk("bp_drained", 64'(rsp_valid_o), 64'd0);

    // Lock together with a write: write lands, later writes rejected
    cfg_lock_i = 1'b1;
    write_rule(3, 48'h9000, 48'h100, 1'b1, 1'b0, "wr3_lock");
    cfg_lock_i = 1'b0;
    chk("locked", 64'(locked_o), 64'd1);
    write_rule(3, 48'hA000, 48'h100, 1'b1, 1'b1, "wr3_locked");
    step();
    chk("lock_err_clear", 64'(cfg_err_o), 64'd0);
    write_rule(0, 48'h0, 48'h0, 1'b0, 1'b1, "wr0_locked");
    lookup(48'h9000, 1'b1, 3, 1'b0, "lock_kept");
    lookup(48'hA000, 1'b0, 0, 1'b0, "lock_unchanged");
    lookup(48'h7810_0000, 1'b1, 0, 1'b0, "lock_rule0");

    // Miss counter saturation
    for (int k = 0; k < 20; k++) begin
      lookup(48'h0, 1'b0, 0, 1'b0, "sat");
    end
    chk("sat_final", 64'(miss_cnt_o), 64'hF);

    // Reset while a response is held
    rsp_ready_i = 1'b0; req_valid_i = 1'b1; req_addr_i = 48'h7800_0000;
    step();
    req_valid_i = 1'b0;
    chk("mid_valid", 64'(rsp_valid_o), 64'd1);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    exp_miss = 0;
    chk("rst2_valid", 64'(rsp_valid_o), 64'd0);
    chk("rst2_ready", 64'(req_ready_o), 64'd1);
    chk("rst2_locked", 64'(locked_o), 64'd0);
    chk("rst2_miss", 64'(miss_cnt_o), 64'd0);
    rsp_ready_i = 1'b1;
    lookup(48'h7800_0000, 1'b0, 0, 1'b0, "rst2_table");
    write_rule(4, 48'hB000, 48'h10, 1'b1, 1'b0, "rst2_unlocked");
    lookup(48'hB00F, 1'b1, 4, 1'b0, "rst2_wr");

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
